// File: rtl/act_sequencer.sv
// Activation sequencer: queues activation instructions, issues one beat per
// enabled cycle, and delays per-beat tags to the accumulator, activation and write-back stages.
module act_sequencer #(
    parameter int MATRIX_WIDTH   = 14,
    parameter int ACC_ADDR_WIDTH = 16,
    parameter int BUF_ADDR_WIDTH = 24,
    parameter int LENGTH_WIDTH   = 32,
    parameter int QUEUE_DEPTH    = 4,
    parameter int ACT_PIPE       = 7,
    parameter int WB_PIPE        = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [4:0]                         instr_opcode,
    input  logic [ACC_ADDR_WIDTH-1:0]          instr_acc_addr,
    input  logic [BUF_ADDR_WIDTH-1:0]          instr_buf_addr,
    input  logic [LENGTH_WIDTH-1:0]            instr_length,
    output logic [ACC_ADDR_WIDTH-1:0]          acc_to_act_addr,
    output logic [3:0]                         activation_function,
    output logic                               signed_not_unsigned,
    output logic [BUF_ADDR_WIDTH-1:0]          act_to_buf_addr,
    output logic                               buf_write_en,
    output logic                               busy,
    output logic                               resource_busy,
    output logic                               done,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

    localparam int D_ACC = MATRIX_WIDTH + 5;
    localparam int D_ACT = D_ACC + ACT_PIPE;
    localparam int D_WB  = D_ACT + WB_PIPE;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    typedef struct packed {
        logic [4:0]                opcode;
        logic [ACC_ADDR_WIDTH-1:0] acc_addr;
        logic [BUF_ADDR_WIDTH-1:0] buf_addr;
        logic [LENGTH_WIDTH-1:0]   length;
    } instr_t;

    // One entry per issue-stage cycle; 'last' without 'beat' is a zero-length done token.
    typedef struct packed {
        logic                      beat;
        logic                      last;
        logic                      sign;
        logic [3:0]                func;
        logic [ACC_ADDR_WIDTH-1:0] acc_addr;
        logic [BUF_ADDR_WIDTH-1:0] buf_addr;
    } tag_t;

    typedef enum logic {IDLE, RUN} state_t;

    instr_t                    q_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]          head_ptr, tail_ptr;
    logic [CNT_W-1:0]          count;
    instr_t                    head;
    logic                      push, pop, pop_en, zero_pop, beat, last_beat;

    state_t                    state, state_next;
    logic [ACC_ADDR_WIDTH-1:0] cur_acc;
    logic [BUF_ADDR_WIDTH-1:0] cur_buf;
    logic [4:0]                cur_op;
    logic [LENGTH_WIDTH-1:0]   remaining;

    tag_t                      pipe [D_WB];
    tag_t                      tag_in;
    logic                      in_flight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instr_ready = enable && (count < CNT_W'(QUEUE_DEPTH));
    assign push        = instr_valid && instr_ready;
    assign head        = q_mem[head_ptr];
    assign beat        = (state == RUN);
    assign last_beat   = beat && (remaining == LENGTH_WIDTH'(1));
    assign pop_en      = enable && pop;
    assign zero_pop    = pop && (head.length == '0);

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        pop        = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head.length != '0) state_next = RUN;
                end
            end
            RUN: begin
                // A zero-length successor is left for IDLE so its done token never shares a slot.
                if (last_beat) begin
                    if (count != '0 && head.length != '0) pop = 1'b1;
                    else                                   state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tag_in = '0;
        if (beat) begin
            tag_in.beat     = 1'b1;
            tag_in.last     = last_beat;
            tag_in.sign     = cur_op[4];
            tag_in.func     = cur_op[3:0];
            tag_in.acc_addr = cur_acc;
            tag_in.buf_addr = cur_buf;
        end else if (zero_pop) begin
            tag_in.last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_acc   <= '0;
            cur_buf   <= '0;
            cur_op    <= '0;
            remaining <= '0;
        end else if (enable) begin
            state <= state_next;
            if (pop && !zero_pop) begin
                cur_acc   <= head.acc_addr;
                cur_buf   <= head.buf_addr;
                cur_op    <= head.opcode;
                remaining <= head.length;
            end else if (beat) begin
                cur_acc   <= cur_acc + 1'b1;
                cur_buf   <= cur_buf + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)   tail_ptr <= ptr_inc(tail_ptr);
            if (pop_en) head_ptr <= ptr_inc(head_ptr);
            if (push && !pop_en)      count <= count + 1'b1;
            else if (!push && pop_en) count <= count - 1'b1;
        end
    end

    // NOTE: queue storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) q_mem[tail_ptr] <= '{instr_opcode, instr_acc_addr, instr_buf_addr, instr_length};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D_WB; i++) pipe[i] <= '0;
        end else if (enable) begin
            pipe[0] <= tag_in;
            for (int i = 1; i < D_WB; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < D_WB; i++) in_flight = in_flight | pipe[i].beat | pipe[i].last;
    end

    assign acc_to_act_addr     = pipe[D_ACC-1].acc_addr;
    assign activation_function = pipe[D_ACT-1].func;
    assign signed_not_unsigned = pipe[D_ACT-1].sign;
    assign act_to_buf_addr     = pipe[D_WB-1].buf_addr;
    assign buf_write_en        = pipe[D_WB-1].beat;
    assign done                = pipe[D_WB-1].last;
    assign busy                = (state == RUN);
    assign resource_busy       = busy | in_flight;
    assign queue_count         = count;

endmodule

// File: tb/tb_act_sequencer.sv
// Directed bench for act_sequencer: outputs are logged every cycle on the falling
// edge, then compared against hand-computed beat timings and addresses.
module tb_act_sequencer;

    localparam int D_ACC = 19;
    localparam int D_ACT = 26;
    localparam int D_WB  = 29;
    localparam int LOG_N = 4096;

    logic        clk = 1'b0;
    logic        rst, enable, instr_valid, instr_ready;
    logic [4:0]  instr_opcode;
    logic [15:0] instr_acc_addr, acc_to_act_addr;
    logic [23:0] instr_buf_addr, act_to_buf_addr;
    logic [31:0] instr_length;
    logic [3:0]  activation_function;
    logic        signed_not_unsigned, buf_write_en, busy, resource_busy, done;
    logic [2:0]  queue_count;

    act_sequencer #(
        .MATRIX_WIDTH(14), .ACC_ADDR_WIDTH(16), .BUF_ADDR_WIDTH(24), .LENGTH_WIDTH(32),
        .QUEUE_DEPTH(4), .ACT_PIPE(7), .WB_PIPE(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_acc_addr(instr_acc_addr), .instr_buf_addr(instr_buf_addr), .instr_length(instr_length),
        .acc_to_act_addr(acc_to_act_addr), .activation_function(activation_function),
        .signed_not_unsigned(signed_not_unsigned), .act_to_buf_addr(act_to_buf_addr),
        .buf_write_en(buf_write_en), .busy(busy), .resource_busy(resource_busy),
        .done(done), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, rbusy, we, done, sign, ready;
        logic [3:0]  func;
        logic [15:0] acc;
        logic [23:0] bufa;
        logic [2:0]  cnt;
    } smp_t;

    smp_t lg [LOG_N];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            lg[cyc].busy  = busy;
            lg[cyc].rbusy = resource_busy;
            lg[cyc].we    = buf_write_en;
            lg[cyc].done  = done;
            lg[cyc].sign  = signed_not_unsigned;
            lg[cyc].ready = instr_ready;
            lg[cyc].func  = activation_function;
            lg[cyc].acc   = acc_to_act_addr;
            lg[cyc].bufa  = act_to_buf_addr;
            lg[cyc].cnt   = queue_count;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one instruction until accepted; p is the log index right after the accepting edge.
    task automatic push(input logic [4:0] op, input logic [15:0] a, input logic [23:0] b,
                        input logic [31:0] len, output int p);
        bit taken = 1'b0;
        instr_opcode   = op;
        instr_acc_addr = a;
        instr_buf_addr = b;
        instr_length   = len;
        instr_valid    = 1'b1;
        for (int w = 0; w < 200 && !taken; w++) begin
            taken = instr_ready;
            tick(1);
        end
        instr_valid = 1'b0;
        p = cyc;
        if (!taken) check("push_timeout", 32'd0, 32'd1);
    endtask

    function automatic int find_busy(input int from);
        for (int i = from; i < cyc; i++) if (lg[i].busy) return i;
        return -1;
    endfunction

    function automatic int count_we(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(lg[i].we);
        return n;
    endfunction

    function automatic int count_done(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(lg[i].done);
        return n;
    endfunction

    task automatic get_issue(input int p, output int ci);
        ci = find_busy(p);
        check("issue_seen", 32'(ci >= 0), 32'd1);
        if (ci < 0) ci = p + 1;
    endtask

    initial begin
        int p, p2, ci, pi, mx, viol, stall_from;
        rst = 1'b1; enable = 1'b1; instr_valid = 1'b0;
        instr_opcode = '0; instr_acc_addr = '0; instr_buf_addr = '0; instr_length = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("rst_busy",  32'(lg[cyc-1].busy),  32'd0);
        check("rst_rbusy", 32'(lg[cyc-1].rbusy), 32'd0);
        check("rst_we",    32'(lg[cyc-1].we),    32'd0);
        check("rst_done",  32'(lg[cyc-1].done),  32'd0);
        check("rst_acc",   32'(lg[cyc-1].acc),   32'd0);
        check("rst_buf",   32'(lg[cyc-1].bufa),  32'd0);
        check("rst_cnt",   32'(lg[cyc-1].cnt),   32'd0);
        check("rst_ready", 32'(lg[cyc-1].ready), 32'd1);

        // Single instruction, length 3
        push(5'b10011, 16'h0010, 24'h000200, 32'd3, p);
        tick(40);
        get_issue(p, ci);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_acc%0d", k),  32'(lg[ci+D_ACC+k].acc),  32'h10 + k);
            check($sformatf("t1_func%0d", k), 32'(lg[ci+D_ACT+k].func), 32'd3);
            check($sformatf("t1_sign%0d", k), 32'(lg[ci+D_ACT+k].sign), 32'd1);
            check($sformatf("t1_we%0d", k),   32'(lg[ci+D_WB+k].we),    32'd1);
            check($sformatf("t1_buf%0d", k),  32'(lg[ci+D_WB+k].bufa),  32'h200 + k);
        end
        check("t1_func_pre", 32'(lg[ci+D_ACT-1].func), 32'd0);
        check("t1_func_post", 32'(lg[ci+D_ACT+3].func), 32'd0);
        check("t1_we_pre",   32'(lg[ci+D_WB-1].we),    32'd0);
        check("t1_we_post",  32'(lg[ci+D_WB+3].we),    32'd0);
        check("t1_done_at",  32'(lg[ci+D_WB+2].done),  32'd1);
        check("t1_done_n",   32'(count_done(p, cyc-1)), 32'd1);
        check("t1_rbusy_fly", 32'(lg[ci+D_WB+1].rbusy), 32'd1);
        check("t1_rbusy_end", 32'(lg[cyc-1].rbusy),    32'd0);

        // Two queued instructions issue back to back
        push(5'b00001, 16'h0020, 24'h000400, 32'd2, p);
        push(5'b00010, 16'h0030, 24'h000500, 32'd2, p2);
        tick(45);
        get_issue(p, ci);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_we%0d", k),   32'(lg[ci+D_WB+k].we), 32'd1);
            check($sformatf("t2_buf%0d", k),  32'(lg[ci+D_WB+k].bufa),
                  (k < 2) ? 32'h400 + k : 32'h500 + k - 2);
            check($sformatf("t2_func%0d", k), 32'(lg[ci+D_ACT+k].func), (k < 2) ? 32'd1 : 32'd2);
        end
        check("t2_we_post", 32'(lg[ci+D_WB+4].we), 32'd0);
        check("t2_done_n",  32'(count_done(p, cyc-1)), 32'd2);

        // Fill the queue while the first instruction runs; the last push must stall
        push(5'b00001, 16'h0000, 24'h000000, 32'd8, p);
        for (int i = 1; i < 5; i++) push(5'(i + 1), 16'h0000, 24'(i * 256), 32'd8, p2);
        stall_from = p2;
        push(5'b00110, 16'h0000, 24'h000500, 32'd8, p2);
        tick(90);
        get_issue(p, ci);
        mx = 0; viol = 0;
        for (int i = p; i < cyc; i++) begin
            if (int'(lg[i].cnt) > mx) mx = int'(lg[i].cnt);
            if (lg[i].cnt == 3'd4 && lg[i].ready) viol++;
        end
        check("t3_max_cnt",   32'(mx), 32'd4);
        check("t3_ready_full", 32'(viol), 32'd0);
        check("t3_stalled",   32'(p2 - stall_from > 1), 32'd1);
        check("t3_cnt_before_accept", 32'(lg[p2-1].cnt), 32'd3);
        for (int j = 0; j < 48; j++) begin
            check($sformatf("t3_we%0d", j),  32'(lg[ci+D_WB+j].we),   32'd1);
            check($sformatf("t3_buf%0d", j), 32'(lg[ci+D_WB+j].bufa), 32'((j / 8) * 256 + (j % 8)));
        end
        check("t3_we_n",   32'(count_we(p, cyc-1)),   32'd48);
        check("t3_done_n", 32'(count_done(p, cyc-1)), 32'd6);

        // Address wrap
        push(5'b00111, 16'hFFFF, 24'hFFFFFF, 32'd2, p);
        tick(40);
        get_issue(p, ci);
        check("t4_acc0", 32'(lg[ci+D_ACC].acc),    32'hFFFF);
        check("t4_acc1", 32'(lg[ci+D_ACC+1].acc),  32'h0000);
        check("t4_buf0", 32'(lg[ci+D_WB].bufa),    32'hFFFFFF);
        check("t4_buf1", 32'(lg[ci+D_WB+1].bufa),  32'h000000);
        check("t4_we_n", 32'(count_we(p, cyc-1)),  32'd2);

        // Zero length: consumed, no beats, done D_WB cycles after the pop cycle
        push(5'b10101, 16'h0055, 24'h000555, 32'd0, p);
        tick(40);
        pi = p;
        for (int i = p; i < p + 5; i++) if (lg[i].cnt == 3'd1) pi = i;
        check("t5_cnt_drained", 32'(lg[pi+1].cnt), 32'd0);
        check("t5_done_at", 32'(lg[pi+D_WB].done), 32'd1);
        check("t5_done_n",  32'(count_done(p, cyc-1)), 32'd1);
        check("t5_we_n",    32'(count_we(p, cyc-1)),   32'd0);
        check("t5_busy",    32'(find_busy(p) < 0),     32'd1);

        // Enable low for 5 cycles right after the first beat
        push(5'b00001, 16'h0040, 24'h000300, 32'd3, p);
        ci = -1;
        for (int w = 0; w < 10 && ci < 0; w++) begin
            if (busy) ci = cyc;
            else      tick(1);
        end
        check("t6_issue_seen", 32'(ci >= 0), 32'd1);
        if (ci < 0) ci = cyc;
        tick(1);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(45);
        check("t6_ready_off", 32'(lg[ci+3].ready), 32'd0);
        check("t6_busy_hold", 32'(lg[ci+3].busy),  32'd1);
        check("t6_acc0", 32'(lg[ci+D_ACC+5].acc),   32'h40);
        check("t6_acc1", 32'(lg[ci+D_ACC+6].acc),   32'h41);
        check("t6_we_early", 32'(lg[ci+D_WB].we),   32'd0);
        check("t6_we_pre",   32'(lg[ci+D_WB+4].we), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6_we%0d", k),  32'(lg[ci+D_WB+5+k].we),   32'd1);
            check($sformatf("t6_buf%0d", k), 32'(lg[ci+D_WB+5+k].bufa), 32'h300 + k);
        end
        check("t6_done_at", 32'(lg[ci+D_WB+7].done), 32'd1);

        // Reset on beat 2 of a length-10 instruction with another queued behind it
        push(5'b00011, 16'h0080, 24'h000600, 32'd10, p);
        push(5'b00100, 16'h0090, 24'h000700, 32'd4, p2);
        tick(1);
        get_issue(p, ci);
        while (cyc < ci + 2) tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(60);
        check("t7_we",    32'(lg[ci+3].we),    32'd0);
        check("t7_done",  32'(lg[ci+3].done),  32'd0);
        check("t7_busy",  32'(lg[ci+3].busy),  32'd0);
        check("t7_rbusy", 32'(lg[ci+3].rbusy), 32'd0);
        check("t7_cnt",   32'(lg[ci+3].cnt),   32'd0);
        check("t7_acc",   32'(lg[ci+3].acc),   32'd0);
        check("t7_ready", 32'(lg[ci+3].ready), 32'd1);
        check("t7_we_n",   32'(count_we(ci+3, cyc-1)),   32'd0);
        check("t7_done_n", 32'(count_done(ci+3, cyc-1)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/act_sequencer.md
ACT_SEQUENCER -- requirements
Module: act_sequencer

Interface
REQ-001 The block SHALL have parameter MATRIX_WIDTH, default 14, systolic array width used in the delay computation.
REQ-002 The block SHALL have parameter ACC_ADDR_WIDTH, default 16, accumulator address width.
REQ-003 The block SHALL have parameter BUF_ADDR_WIDTH, default 24, unified buffer address width.
REQ-004 The block SHALL have parameter LENGTH_WIDTH, default 32, beat-count width.
REQ-005 The block SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries; any integer >= 2 is legal.
REQ-006 The block SHALL have parameter ACT_PIPE, default 7, activation unit latency in cycles.
REQ-007 The block SHALL have parameter WB_PIPE, default 3, write-back latency in cycles.
REQ-008 The block SHALL have these ports, one per line:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  global advance; 0 freezes all state.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  queue can accept.
- instr_opcode  in  5  bit4 signed_not_unsigned, bits3:0 activation function.
- instr_acc_addr  in  ACC_ADDR_WIDTH  first accumulator address.
- instr_buf_addr  in  BUF_ADDR_WIDTH  first buffer address.
- instr_length  in  LENGTH_WIDTH  number of beats.
- acc_to_act_addr  out  ACC_ADDR_WIDTH  accumulator read address.
- activation_function  out  4  function for the current beat.
- signed_not_unsigned  out  1  signedness for the current beat.
- act_to_buf_addr  out  BUF_ADDR_WIDTH  buffer write address.
- buf_write_en  out  1  buffer write strobe.
- busy  out  1  issue stage running.
- resource_busy  out  1  issue running or any beat in flight.
- done  out  1  one-cycle pulse when an instruction's last write exits.
- queue_count  out  clog2(QUEUE_DEPTH+1)  occupied queue entries.

Function
REQ-009 Delays SHALL be D_ACC = MATRIX_WIDTH+5, D_ACT = D_ACC+ACT_PIPE, D_WB = D_ACT+WB_PIPE, measured from issue-stage beat to output.
REQ-010 instr_ready SHALL equal enable AND (queue_count < QUEUE_DEPTH), registered-count based, with no pass-through when full even if a pop occurs in the same cycle.
REQ-011 A push SHALL occur when instr_valid and instr_ready are both 1; simultaneous push and pop SHALL leave queue_count unchanged.
REQ-012 The issue FSM SHALL have two states. IDLE: if queue non-empty, pop head, load counters, go to RUN. RUN: emit one beat per enabled cycle; on the last beat, pop next and stay in RUN if queue non-empty, else go to IDLE.
REQ-013 Back-to-back instructions SHALL issue with zero bubble cycles between the last beat of one and the first beat of the next.
REQ-014 Beat k of an instruction SHALL carry acc address instr_acc_addr+k and buffer address instr_buf_addr+k, each wrapping modulo 2^width.
REQ-015 Each beat SHALL carry its own function/sign/write tag through the delay lines, so adjacent instructions with different opcodes never mix.
REQ-016 instr_length = 0 SHALL consume the instruction, emit no beats, and pulse done D_WB cycles after the pop.
REQ-017 Outputs acc_to_act_addr, activation_function/signed_not_unsigned, and act_to_buf_addr/buf_write_en SHALL present beat k exactly D_ACC, D_ACT, and D_WB enabled cycles after its issue.
REQ-018 activation_function, signed_not_unsigned, and buf_write_en SHALL be 0 on non-beat cycles.
REQ-019 busy SHALL be 1 exactly in RUN; resource_busy SHALL be 1 while busy or while any beat is inside the D_WB pipeline.
REQ-020 With enable = 0, no state SHALL change, the queue SHALL not push or pop, and outputs SHALL hold.

Reset
REQ-021 On rst = 1, FSM SHALL go to IDLE, queue SHALL empty, all delay lines SHALL clear, and every output SHALL read 0 except instr_ready, which SHALL read enable the cycle after reset.
REQ-022 rst asserted mid-instruction SHALL discard all queued and in-flight beats, with no buf_write_en and no done after the reset edge.

Verification
REQ-023 Single instruction, opcode 5'b10011, acc 0x10, buf 0x200, length 3 -> acc_to_act_addr 0x10..0x12 at D_ACC=19; function 3, sign 1 at D_ACT=26; buf_write_en with 0x200..0x202 at D_WB=29; one done pulse.
REQ-024 Two queued instructions (opcode 1, length 2; opcode 2, length 2) -> four contiguous write beats; functions 1,1,2,2; two done pulses.
REQ-025 Push 5 instructions with QUEUE_DEPTH=4 while the first runs -> instr_ready drops at count 4, fifth accepted only after a pop, none lost.
REQ-026 acc 0xFFFF, buf 0xFFFFFF, length 2 -> addresses 0xFFFF,0x0000 and 0xFFFFFF,0x000000.
REQ-027 length 0 -> no buf_write_en, done pulse at D_WB; enable low 5 cycles mid-run -> outputs shifted by exactly 5 cycles.
REQ-028 rst asserted on beat 2 of length 10 -> all outputs 0 next cycle, queue_count 0, no further writes.
